// File: rtl/hart_mem_pkg.sv
// Shared widths, derivation helpers and parameter bounds for the hart memory bank.
package hart_mem_pkg;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;
    localparam int RSP_CTRL_W     = 2;  // {wen, err} carried beside rdata

    function automatic int mask_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_w(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 0;
    endfunction

    function automatic int rsp_w(input int data_w);
        return data_w + RSP_CTRL_W;
    endfunction

endpackage

// File: rtl/hart_mem_bank_if.sv
// Request/response handshake bundle between a hart (master) and the memory bank (slave).
interface hart_mem_bank_if
    import hart_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int MASK_W = mask_w(DATA_W);

    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_wen;
    logic [ADDR_W-1:0] i_req_addr;
    logic [DATA_W-1:0] i_req_wdata;
    logic [MASK_W-1:0] i_req_mask;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_rdata;
    logic              o_rsp_err;
    logic              o_rsp_wen;

    modport master (
        output i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_mask, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_wen
    );

    modport slave (
        input  i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_mask, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_wen
    );

endinterface

// File: rtl/hart_mem_rsp_fifo.sv
// Synchronous FIFO with extra-MSB pointers so full and empty are distinguishable.
module hart_mem_rsp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/hart_mem_bank.sv
// Byte-lane memory bank: masked writes, fixed-latency reads, credit-limited in-order responses.
module hart_mem_bank
    import hart_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int RD_LATENCY  = 1,
    parameter int RSP_DEPTH   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    hart_mem_bank_if.slave    bus
);

    localparam int MASK_W = mask_w(DATA_W);
    localparam int OFF_W  = off_w(DATA_W);
    localparam int WORDS  = DEPTH_BYTES / MASK_W;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int RSP_W  = rsp_w(DATA_W);
    localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
    localparam int CR_W   = CNT_W + 1;

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("hart_mem_bank: RD_LATENCY out of range");
    end
    if (RSP_DEPTH < 2 || RSP_DEPTH < RD_LATENCY) begin : g_bad_depth
        $error("hart_mem_bank: RSP_DEPTH too small");
    end

    logic                  w_misalign;
    logic                  w_oor;
    logic                  w_err;
    logic                  w_acc;
    logic                  w_wr;
    logic                  w_zero_rd;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_W-1:0]     w_rdata_p0;
    logic [DATA_W-1:0]     w_rdata_out;
    logic [RD_LATENCY-1:0] r_vld_p;
    logic [RD_LATENCY-1:0] r_wen_p;
    logic [RD_LATENCY-1:0] r_err_p;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_cnt;
    logic [CR_W-1:0]       w_credits;
    logic [RSP_W-1:0]      w_head;

    assign w_misalign = |(bus.i_req_addr & ADDR_W'(MASK_W - 1));
    assign w_oor      = bus.i_req_addr > ADDR_W'(DEPTH_BYTES - MASK_W);
    assign w_err      = w_misalign | w_oor;
    assign w_acc      = i_rst_n & bus.i_req_valid & bus.o_req_ready;
    assign w_wr       = w_acc & bus.i_req_wen & ~w_err;
    assign w_zero_rd  = bus.i_req_wen | w_err;
    assign w_idx      = bus.i_req_addr[OFF_W +: IDX_W];

    // Stage 0: one byte-wide array per lane; the lane read register is the first latency stage
    for (genvar k = 0; k < MASK_W; k++) begin : g_lane
        logic [7:0] r_mem [WORDS];
        logic [7:0] r_rd_p0;

        always_ff @(posedge i_clk) begin
            if (w_wr && bus.i_req_mask[k]) r_mem[w_idx] <= bus.i_req_wdata[8*k +: 8];
            if (w_acc) r_rd_p0 <= w_zero_rd ? 8'h00 : r_mem[w_idx];
        end

        assign w_rdata_p0[8*k +: 8] = r_rd_p0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_acc;
            for (int i = 1; i < RD_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        r_wen_p[0] <= bus.i_req_wen;
        r_err_p[0] <= w_err;
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_wen_p[i] <= r_wen_p[i-1];
            r_err_p[i] <= r_err_p[i-1];
        end
    end

    // Stages 1..RD_LATENCY-1: plain shift of read data
    if (RD_LATENCY > 1) begin : g_rd_shift
        logic [DATA_W-1:0] r_rdata_pn [RD_LATENCY-1];

        always_ff @(posedge i_clk) begin
            r_rdata_pn[0] <= w_rdata_p0;
            for (int i = 1; i < RD_LATENCY - 1; i++) r_rdata_pn[i] <= r_rdata_pn[i-1];
        end

        assign w_rdata_out = r_rdata_pn[RD_LATENCY-2];
    end else begin : g_rd_direct
        assign w_rdata_out = w_rdata_p0;
    end

    assign w_push = r_vld_p[RD_LATENCY-1];
    assign w_pop  = ~w_fifo_empty & bus.i_rsp_ready;

    hart_mem_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data ({r_wen_p[RD_LATENCY-1], r_err_p[RD_LATENCY-1], w_rdata_out}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_cnt)
    );

    // Every request holds a credit from accept until its response is popped
    always_comb begin
        w_credits = CR_W'(w_fifo_cnt);
        for (int i = 0; i < RD_LATENCY; i++) w_credits = w_credits + CR_W'(r_vld_p[i]);
    end

    assign bus.o_req_ready = (w_credits < CR_W'(RSP_DEPTH));
    assign bus.o_rsp_valid = ~w_fifo_empty;
    assign {bus.o_rsp_wen, bus.o_rsp_err, bus.o_rsp_rdata} = w_fifo_empty ? '0 : w_head;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(w_push && w_fifo_full));

endmodule

// File: tb/tb_hart_mem_bank.sv
// Directed bench for hart_mem_bank with RD_LATENCY=2, RSP_DEPTH=4.
module tb_hart_mem_bank;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int DEPTH_BYTES = 1024;
    localparam int RD_LATENCY  = 2;
    localparam int RSP_DEPTH   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hart_mem_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    hart_mem_bank #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH_BYTES (DEPTH_BYTES),
        .RD_LATENCY  (RD_LATENCY),
        .RSP_DEPTH   (RSP_DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_t = 0;
    logic [33:0] q_rsp [$];
    int          q_t [$];
    logic [31:0] words [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Responses are taken on the edge after this sample point
    always @(negedge clk) begin
        if (rst_n && bus.o_rsp_valid && bus.i_rsp_ready) begin
            q_rsp.push_back({bus.o_rsp_wen, bus.o_rsp_err, bus.o_rsp_rdata});
            q_t.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask);
        int n;
        n = 0;
        bus.i_req_valid = 1'b1;
        bus.i_req_wen   = wen;
        bus.i_req_addr  = addr;
        bus.i_req_wdata = wdata;
        bus.i_req_mask  = mask;
        @(negedge clk);
        while (!bus.o_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_ready", 64'(bus.o_req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic wen, input logic err, input logic [31:0] rdata);
        int          n;
        logic [33:0] got;
        n = 0;
        while (q_rsp.size() == 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q_rsp.size() == 0) begin
            chk({tag, "_tmo"}, 64'(q_rsp.size()), 64'd1);
        end else begin
            got    = q_rsp.pop_front();
            last_t = q_t.pop_front();
            chk(tag, 64'(got), 64'({wen, err, rdata}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_acc;
        int first_t;

        words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
                  32'hDEAABEBB, 32'h0BADF00D, 32'hCAFEBABE, 32'h12345678};
        bus.i_req_valid = 1'b0;
        bus.i_req_wen   = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_wdata = '0;
        bus.i_req_mask  = '0;
        bus.i_rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.o_req_ready), 64'd1);
        chk("rst_valid", 64'(bus.o_rsp_valid), 64'd0);
        chk("rst_err",   64'(bus.o_rsp_err),   64'd0);
        chk("rst_wen",   64'(bus.o_rsp_wen),   64'd0);
        chk("rst_rdata", 64'(bus.o_rsp_rdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-word write then read back
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        send(1'b0, 32'h10, 32'h0, 4'b0000);
        expect_rsp("t1_wr", 1'b1, 1'b0, 32'h0);
        expect_rsp("t1_rd", 1'b0, 1'b0, 32'hDEADBEEF);

        // Mask 0101 replaces bytes 0 and 2, bytes 1 and 3 are retained
        send(1'b1, 32'h10, 32'h00AA00BB, 4'b0101);
        send(1'b0, 32'h10, 32'h0, 4'b0000);
        expect_rsp("t2_wr", 1'b1, 1'b0, 32'h0);
        expect_rsp("t2_rd", 1'b0, 1'b0, 32'hDEAABEBB);

        for (int i = 0; i < 8; i++) begin
            if (i != 4) begin
                send(1'b1, 32'(i * 4), words[i], 4'b1111);
                expect_rsp($sformatf("prep_wr%0d", i), 1'b1, 1'b0, 32'h0);
            end
        end

        // Error paths and range boundary
        send(1'b0, 32'h12, 32'h0, 4'b0000);
        send(1'b0, 32'h400, 32'h0, 4'b0000);
        send(1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111);
        send(1'b0, 32'h0, 32'h0, 4'b0000);
        send(1'b1, 32'h12, 32'hFFFFFFFF, 4'b1111);
        send(1'b0, 32'h10, 32'h0, 4'b0000);
        send(1'b1, 32'h3FC, 32'hA5A5A5A5, 4'b1111);
        send(1'b0, 32'h3FC, 32'h0, 4'b0000);
        send(1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000);
        send(1'b0, 32'h14, 32'h0, 4'b0000);
        expect_rsp("t3_rd_mis",   1'b0, 1'b1, 32'h0);
        expect_rsp("t3_rd_oor",   1'b0, 1'b1, 32'h0);
        expect_rsp("t3_wr_oor",   1'b1, 1'b1, 32'h0);
        expect_rsp("t3_rd_w0",    1'b0, 1'b0, 32'h11223344);
        expect_rsp("t3_wr_mis",   1'b1, 1'b1, 32'h0);
        expect_rsp("t3_rd_w10",   1'b0, 1'b0, 32'hDEAABEBB);
        expect_rsp("t3_wr_top",   1'b1, 1'b0, 32'h0);
        expect_rsp("t3_rd_top",   1'b0, 1'b0, 32'hA5A5A5A5);
        expect_rsp("t3_wr_mask0", 1'b1, 1'b0, 32'h0);
        expect_rsp("t3_rd_w14",   1'b0, 1'b0, 32'h0BADF00D);

        // Back-pressure: four credits, then the bank stalls
        bus.i_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 32'(i * 4), 32'h0, 4'b0000);
        chk("t4_rdy_drop", 64'(bus.o_req_ready), 64'd0);
        bus.i_req_valid = 1'b1;
        bus.i_req_wen   = 1'b0;
        bus.i_req_addr  = 32'h10;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_rdy_held", 64'(bus.o_req_ready), 64'd0);
        chk("t4_rsp_vld",  64'(bus.o_rsp_valid), 64'd1);
        chk("t4_head",     64'(bus.o_rsp_rdata), 64'h11223344);
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_rsp($sformatf("t4_drain%0d", i), 1'b0, 1'b0, words[i]);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_rdy_back", 64'(bus.o_req_ready), 64'd1);
        chk("t4_no5th",    64'(q_rsp.size()),    64'd0);
        chk("t4_empty",    64'(bus.o_rsp_valid), 64'd0);

        // Streaming reads at one per cycle
        t_acc = 0;
        for (int i = 0; i < 8; i++) begin
            bus.i_req_valid = 1'b1;
            bus.i_req_wen   = 1'b0;
            bus.i_req_addr  = 32'(i * 4);
            @(negedge clk);
            if (i == 0) t_acc = cyc + 1;
            chk($sformatf("t5_rdy%0d", i), 64'(bus.o_req_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.i_req_valid = 1'b0;
        expect_rsp("t5_rd0", 1'b0, 1'b0, words[0]);
        chk("t5_latency", 64'(last_t - t_acc), 64'(RD_LATENCY));
        first_t = last_t;
        for (int i = 1; i < 8; i++) expect_rsp($sformatf("t5_rd%0d", i), 1'b0, 1'b0, words[i]);
        chk("t5_thruput", 64'(last_t - first_t), 64'd7);

        // Reset with two reads in flight and a write presented during reset
        send(1'b0, 32'h4, 32'h0, 4'b0000);
        send(1'b0, 32'h8, 32'h0, 4'b0000);
        bus.i_req_valid = 1'b1;
        bus.i_req_wen   = 1'b1;
        bus.i_req_addr  = 32'h0;
        bus.i_req_wdata = 32'hFFFFFFFF;
        bus.i_req_mask  = 4'b1111;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_req_valid = 1'b0;
        chk("t6_ready", 64'(bus.o_req_ready), 64'd1);
        chk("t6_valid", 64'(bus.o_rsp_valid), 64'd0);
        chk("t6_rdata", 64'(bus.o_rsp_rdata), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_no_stale", 64'(q_rsp.size()), 64'd0);
        send(1'b0, 32'h0, 32'h0, 4'b0000);
        send(1'b0, 32'h8, 32'h0, 4'b0000);
        expect_rsp("t6_keep_w0", 1'b0, 1'b0, words[0]);
        expect_rsp("t6_keep_w8", 1'b0, 1'b0, words[2]);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
